// File: rtl/sr04_pkg.sv
// Shared types and default timing constants for the HC-SR04 ranging engine.
package sr04_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_HOLD
    } state_t;

    localparam int MM_DIV      = 280;
    localparam int TRIG_CYC    = 480;
    localparam int PERIOD_CYC  = 2_880_000;
    localparam int RISE_TO_CYC = 96_000;
    localparam int MAX_MM      = 4000;
    localparam int ERR_CODE    = 9999;

endpackage

// File: rtl/sr04_ranger_if.sv
// Sensor-side and result signals of the ranging engine, bundled for port hookup.
interface sr04_ranger_if;
    logic        echo;
    logic        trig;
    logic [15:0] dis;
    logic        dis_vld;
    logic        err;

    modport master (input echo, output trig, dis, dis_vld, err);
    modport slave  (output echo, input trig, dis, dis_vld, err);
endinterface

// File: rtl/echo_sync.sv
// Two-flop synchronizer for an asynchronous level input, with rise/fall pulses
// derived from the synchronized level and one registered copy of it.
module echo_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = async_i;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;
endmodule

// File: rtl/sr04_ranger.sv
// HC-SR04 ranging engine: periodic trigger, echo-width timing, and conversion
// of the width straight into whole millimetres (or an error code).
module sr04_ranger #(
    parameter int MM_DIV      = sr04_pkg::MM_DIV,
    parameter int TRIG_CYC    = sr04_pkg::TRIG_CYC,
    parameter int PERIOD_CYC  = sr04_pkg::PERIOD_CYC,
    parameter int RISE_TO_CYC = sr04_pkg::RISE_TO_CYC,
    parameter int MAX_MM      = sr04_pkg::MAX_MM,
    parameter int ERR_CODE    = sr04_pkg::ERR_CODE
) (
    input  logic            clk,
    input  logic            rst_n,
    sr04_ranger_if.master   bus
);
    import sr04_pkg::*;

    localparam logic [21:0] PER_LAST  = 22'(PERIOD_CYC - 1);
    localparam logic [21:0] TRIG_LAST = 22'(TRIG_CYC - 1);
    localparam logic [21:0] RTO_LAST  = 22'(RISE_TO_CYC - 1);
    localparam logic [8:0]  PSC_LAST  = 9'(MM_DIV - 1);
    localparam logic [12:0] MM_MAX    = 13'(MAX_MM);
    localparam logic [15:0] ERR_VAL   = 16'(ERR_CODE);

    logic echo_s, echo_rise, echo_fall;

    echo_sync u_echo_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (bus.echo),
        .sync_o  (echo_s),
        .rise_o  (echo_rise),
        .fall_o  (echo_fall)
    );

    state_t      state_q, state_d;
    logic [21:0] per_q, per_d;
    logic [21:0] tmr_q, tmr_d;
    logic [8:0]  psc_q, psc_d;
    logic [12:0] mm_q, mm_d;
    logic        pend_q, pend_d;
    logic [15:0] dis_q, dis_d;
    logic        err_q, err_d;
    logic        vld_q, vld_d;
    logic        trig_q, trig_d;
    logic        wrap;

    always_comb begin
        state_d = state_q;
        per_d   = (per_q == PER_LAST) ? 22'd0 : per_q + 22'd1;
        tmr_d   = tmr_q;
        psc_d   = psc_q;
        mm_d    = mm_q;
        pend_d  = pend_q;
        dis_d   = dis_q;
        err_d   = err_q;
        vld_d   = 1'b0;
        wrap    = (psc_q == PSC_LAST);

        // A wrap seen while busy or while echo is stuck high is remembered
        // so the next trigger fires as soon as the line is quiet.
        if (per_q == 22'd0) pend_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if ((per_q == 22'd0 || pend_q) && !echo_s) begin
                    state_d = S_TRIG;
                    tmr_d   = 22'd0;
                    per_d   = 22'd1;
                    pend_d  = 1'b0;
                end
            end
            S_TRIG: begin
                if (tmr_q == TRIG_LAST) begin
                    state_d = S_WAIT_RISE;
                    tmr_d   = 22'd0;
                end else begin
                    tmr_d = tmr_q + 22'd1;
                end
            end
            S_WAIT_RISE: begin
                if (echo_rise) begin
                    state_d = S_MEASURE;
                    psc_d   = 9'd0;
                    mm_d    = 13'd0;
                end else if (tmr_q == RTO_LAST) begin
                    state_d = S_IDLE;
                    dis_d   = ERR_VAL;
                    err_d   = 1'b1;
                    vld_d   = 1'b1;
                end else begin
                    tmr_d = tmr_q + 22'd1;
                end
            end
            S_MEASURE: begin
                // The fall cycle itself is counted, so a width of N*MM_DIV reads N.
                if (echo_fall) begin
                    state_d = S_IDLE;
                    vld_d   = 1'b1;
                    if (wrap && mm_q == MM_MAX) begin
                        dis_d = ERR_VAL;
                        err_d = 1'b1;
                    end else begin
                        dis_d = {3'd0, wrap ? mm_q + 13'd1 : mm_q};
                        err_d = 1'b0;
                    end
                end else if (wrap) begin
                    psc_d = 9'd0;
                    if (mm_q == MM_MAX) begin
                        state_d = S_HOLD;
                        dis_d   = ERR_VAL;
                        err_d   = 1'b1;
                        vld_d   = 1'b1;
                    end else begin
                        mm_d = mm_q + 13'd1;
                    end
                end else begin
                    psc_d = psc_q + 9'd1;
                end
            end
            S_HOLD: begin
                if (echo_fall) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        trig_d = (state_d == S_TRIG);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            per_q   <= 22'd0;
            tmr_q   <= 22'd0;
            psc_q   <= 9'd0;
            mm_q    <= 13'd0;
            pend_q  <= 1'b0;
            dis_q   <= 16'd0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            tmr_q   <= tmr_d;
            psc_q   <= psc_d;
            mm_q    <= mm_d;
            pend_q  <= pend_d;
            dis_q   <= dis_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            trig_q  <= trig_d;
        end
    end

    assign bus.trig    = trig_q;
    assign bus.dis     = dis_q;
    assign bus.err     = err_q;
    assign bus.dis_vld = vld_q;
endmodule

// File: tb/tb_sr04_ranger.sv
// Directed bench for sr04_ranger with timing parameters scaled down so whole
// measurement periods fit in a short run.
module tb_sr04_ranger;
    localparam int P_DIV  = 10;
    localparam int P_TRIG = 12;
    localparam int P_PER  = 3000;
    localparam int P_RTO  = 200;
    localparam int P_MAX  = 100;
    localparam int P_ERR  = 9999;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    sr04_ranger_if bus();

    sr04_ranger #(
        .MM_DIV      (P_DIV),
        .TRIG_CYC    (P_TRIG),
        .PERIOD_CYC  (P_PER),
        .RISE_TO_CYC (P_RTO),
        .MAX_MM      (P_MAX),
        .ERR_CODE    (P_ERR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc     = 0;
    int vld_cnt = 0;
    int checks   = 0;
    int failures = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.dis_vld === 1'b1) vld_cnt <= vld_cnt + 1;
    end

    typedef struct {
        int width;
        int delay;
        int exp_dis;
        int exp_err;
        int vld_now;
    } vec_t;

    vec_t vecs [10];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Returns the cycle stamp at which trig was first seen high, then waits for it to drop.
    task automatic wait_trig(output int rc);
        int n;
        n  = 0;
        rc = 0;
        while (bus.trig !== 1'b1 && n < 2 * P_PER) begin
            tick(1);
            n++;
        end
        chk("trig_rise_timeout", int'(n >= 2 * P_PER), 0);
        rc = cyc;
        n  = 0;
        while (bus.trig === 1'b1 && n < 4 * P_TRIG) begin
            tick(1);
            n++;
        end
        chk("trig_fall_timeout", int'(n >= 4 * P_TRIG), 0);
    endtask

    initial begin
        int rc, rc_prev, n, v0, highs;

        vecs[0] = '{300,  50,  30,    0, 1};
        vecs[1] = '{9,    20,  0,     0, 1};
        vecs[2] = '{10,   20,  1,     0, 1};
        vecs[3] = '{19,   20,  1,     0, 1};
        vecs[4] = '{1000, 100, 100,   0, 1};
        vecs[5] = '{1009, 20,  100,   0, 1};
        vecs[6] = '{1010, 20,  P_ERR, 1, 1};
        vecs[7] = '{1020, 20,  P_ERR, 1, 0};
        vecs[8] = '{0,    0,   P_ERR, 1, 1};
        vecs[9] = '{50,   20,  5,     0, 1};

        bus.echo = 1'b0;
        rst_n    = 1'b0;
        tick(3);
        chk("rst_trig", int'(bus.trig), 0);
        chk("rst_dis", int'(bus.dis), 0);
        chk("rst_err", int'(bus.err), 0);
        chk("rst_vld", int'(bus.dis_vld), 0);

        rst_n = 1'b1;
        tick(1);
        chk("first_trig", int'(bus.trig), 1);
        rc_prev = cyc;
        n = 0;
        while (bus.trig === 1'b1 && n < 1000) begin
            n++;
            tick(1);
        end
        chk("trig_width", n, P_TRIG);

        for (int i = 0; i < 10; i++) begin
            wait_trig(rc);
            chk($sformatf("period_%0d", i), rc - rc_prev, P_PER);
            rc_prev = rc;
            v0 = vld_cnt;
            if (vecs[i].width == 0) begin
                tick(P_RTO - 1);
                chk($sformatf("pre_vld_%0d", i), int'(bus.dis_vld), 0);
                tick(1);
            end else begin
                tick(vecs[i].delay);
                bus.echo = 1'b1;
                tick(vecs[i].width);
                bus.echo = 1'b0;
                tick(2);
                chk($sformatf("pre_vld_%0d", i), int'(bus.dis_vld), 0);
                tick(1);
            end
            chk($sformatf("dis_%0d", i), int'(bus.dis), vecs[i].exp_dis);
            chk($sformatf("err_%0d", i), int'(bus.err), vecs[i].exp_err);
            chk($sformatf("vld_now_%0d", i), int'(bus.dis_vld), vecs[i].vld_now);
            tick(2);
            chk($sformatf("vld_count_%0d", i), vld_cnt - v0, 1);
        end

        // Echo stuck high in IDLE across the period wrap: no trigger until it drops.
        v0 = vld_cnt;
        highs = 0;
        bus.echo = 1'b1;
        while (cyc < rc_prev + P_PER + 20) begin
            tick(1);
            if (bus.trig === 1'b1) highs++;
        end
        chk("stuck_no_trig", highs, 0);
        chk("stuck_vld", vld_cnt - v0, 0);
        chk("stuck_dis", int'(bus.dis), 5);
        bus.echo = 1'b0;
        tick(2);
        chk("stuck_trig_early", int'(bus.trig), 0);
        tick(1);
        chk("stuck_trig_fire", int'(bus.trig), 1);

        // Reset asserted in the middle of a measurement.
        wait_trig(rc);
        tick(10);
        bus.echo = 1'b1;
        tick(60);
        v0 = vld_cnt;
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_trig", int'(bus.trig), 0);
        chk("midrst_dis", int'(bus.dis), 0);
        chk("midrst_err", int'(bus.err), 0);
        chk("midrst_vld", int'(bus.dis_vld), 0);
        tick(4);
        bus.echo = 1'b0;
        tick(6);
        chk("midrst_no_vld", vld_cnt - v0, 0);
        chk("midrst_dis_hold", int'(bus.dis), 0);
        rst_n = 1'b1;
        tick(1);
        chk("midrst_retrig", int'(bus.trig), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sr04_ranger.md
# sr04_ranger

Upstream ranging engine for the HC-SR04 ultrasonic distance display. It fires the sensor's trigger pulse on a fixed measurement period and times the returned echo pulse. It converts the echo width directly into whole millimetres on `dis[15:0]` for the latch/BCD/segment chain downstream. No-echo and out-of-range conditions produce a distinctive error code that the 4-digit display can show.

## Interface
Parameters:
- `MM_DIV`, 280: clocks per 1 mm of distance. At 48 MHz, 2 mm of round-trip travel at 343 m/s takes 5.83 µs.
- `TRIG_CYC`, 480: trigger high time in clocks (10 µs).
- `PERIOD_CYC`, 2_880_000: trigger-to-trigger period (60 ms).
- `RISE_TO_CYC`, 96_000: maximum wait from trigger fall to echo rise (2 ms).
- `MAX_MM`, 4000: largest valid distance.
- `ERR_CODE`, 9999: value driven on `dis` for no-echo or out-of-range.

Ports:
- `clk`, in, 1: system clock, 48 MHz.
- `rst_n`, in, 1: reset. Asynchronous, active-low.
- `echo`, in, 1: sensor echo, asynchronous to `clk`.
- `trig`, out, 1: sensor trigger.
- `dis`, out, 16: last distance in mm (0..`MAX_MM`) or `ERR_CODE`.
- `dis_vld`, out, 1: one-cycle pulse when `dis` updates.
- `err`, out, 1: high while `dis` holds `ERR_CODE`.

## Operation
- `echo` passes through a 2-FF synchronizer, giving `echo_s`. A rise/fall detector runs on `echo_s` and a registered copy of it.
- The period counter runs freely from reset, counts `0..PERIOD_CYC-1`, and wraps.
- The FSM has five states:
  - IDLE → TRIG: when the period counter is 0 and `echo_s` is 0.
    - If `echo_s` is 1 at wrap, wait in IDLE until it falls.
    - Then start the trigger and restart the period counter at 0.
  - TRIG: `trig`=1 for exactly `TRIG_CYC` clocks, then go to WAIT_RISE with `trig`=0.
  - WAIT_RISE:
    - On an `echo_s` rise, go to MEASURE. Clear the prescaler and the mm counter.
    - If `RISE_TO_CYC` clocks elapse first, this is an error result; go to IDLE.
  - MEASURE:
    - The prescaler counts `0..MM_DIV-1`. The mm counter increments on each wrap, so the result is truncated.
    - On an `echo_s` fall, this is a valid result with value = mm count; go to IDLE.
    - If the mm count would exceed `MAX_MM`, this is an error result; go to HOLD.
  - HOLD: wait for an `echo_s` fall, then go to IDLE. No result is issued on that fall.
- Result issue:
  - Valid result: `dis` ← mm count, `err` ← 0, `dis_vld` pulses.
  - Error result: `dis` ← `ERR_CODE`, `err` ← 1, `dis_vld` pulses.
- `dis` and `err` hold their values between results.
- Width rules:
  - Mm counter: 13 bits.
  - Prescaler: 9 bits.
  - Period and timeout counters: 22 bits.
  - `dis` is zero-extended to 16 bits.

## Timing
- Reset values: `trig`=0, `dis`=0, `dis_vld`=0, `err`=0. The FSM is in IDLE and the period counter is 0.
- First trigger: `trig` rises on the first clock after `rst_n` deasserts, provided `echo_s`=0.
- Echo latency: 2 clocks from the echo pin to `echo_s`, plus 1 clock for edge detection. Both edges are delayed equally, so the measured width equals the pin width ±1 clock.
- Result timing: `dis` and `err` update, and `dis_vld` pulses, in the clock following the detected `echo_s` fall, timeout, or overflow.
- Echo pulses arriving in IDLE or TRIG are ignored.
- Reset asserted mid-measurement: the block returns immediately to the reset values, and the result in progress is discarded.
- Boundary value: exactly `MAX_MM` mm is valid. Error is raised only at `MAX_MM`+1.

## Structure
- A shared package `sr04_pkg` holds:
  - the FSM state enum;
  - the default constants `MM_DIV`, `TRIG_CYC`, `PERIOD_CYC`, `RISE_TO_CYC`, `MAX_MM`, `ERR_CODE`.
- Sub-module `echo_sync`: 2-FF synchronizer plus rise/fall pulse outputs. It is reusable for other asynchronous sensor inputs.

## Test plan
Use default parameters unless noted.
- **Reset state:** hold `rst_n`=0 → `trig`=0, `dis`=0, `err`=0. Release reset → `trig` is high for exactly 480 clocks.
- **Valid echo:** echo high for 280,000 clocks, rising 1,000 clocks after trigger fall → `dis`=1000, `err`=0, one `dis_vld` pulse. Echo high for 279 clocks → `dis`=0.
- **No echo:** echo never rises → 96,000 clocks after trigger fall, `dis`=9999, `err`=1, `dis_vld` pulses. The next trigger fires 2,880,000 clocks after the previous one.
- **Range boundary:** echo width 4000×280 clocks → `dis`=4000, `err`=0. Echo width 4001×280+10 clocks → `dis`=9999, `err`=1, with no second `dis_vld` at the echo fall.
- **Stuck-high echo:** echo held high across the period wrap → no trigger is issued. The trigger fires on the first clock after `echo_s` falls.
- **Reset mid-measurement:** assert `rst_n`=0 in MEASURE → outputs return to reset values immediately, with no `dis_vld` pulse.
